axis_video_checker: RTL and testbench
=====================================

Name: axis_video_checker

Overview:
- Synthesisable AXI-Stream video sink/monitor for the pixel generator output path; replaces the simulation-only ready generator and SOF/EOL checker in bench tops.
- Drives tready in selectable backpressure modes, tracks word/line/frame position, and counts framing errors and valid-timeouts in saturating counters.
- Readable by the bench and usable on-chip behind a debug register bank.

Parameters:
- DATA_W, 32, tdata width in bits.
- X_SIZE, 480, words per line.
- Y_SIZE, 480, lines per frame.
- TIMEOUT, 1000, cycles of tvalid low before a timeout error; 0 disables the timeout check.
- ERR_W, 16, width of each error counter.
- RND_SEED, 1246504138, 33-bit PRBS seed.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_tdata  in  DATA_W  stream data.
- s_tvalid  in  1  stream valid.
- s_tuser  in  1  start of frame (SOF).
- s_tlast  in  1  end of line (EOL).
- s_tready  out  1  stream ready (registered).
- ready_mode  in  2  0 always, 1 PRBS, 2 ready-after-valid, 3 stall.
- clear_errors  in  1  synchronous clear of error counters and err_any.
- x_pos  out  16  current word index in line.
- y_pos  out  16  current line index.
- frame_count  out  16  SOFs accepted, wraps.
- frame_done  out  1  one-cycle pulse after the last EOL of a frame.
- err_sof_missing  out  ERR_W  missing-SOF error count.
- err_sof_unexpected  out  ERR_W  unexpected-SOF error count.
- err_eol_missing  out  ERR_W  missing-EOL error count.
- err_eol_unexpected  out  ERR_W  unexpected-EOL error count.
- err_timeout  out  ERR_W  timeout error count.
- err_any  out  1  sticky OR of all error events.
- checksum  out  32  frame checksum (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - s_tready=0; prbs=RND_SEED.
  - x_pos, y_pos, frame_count, all error counters, err_any, frame_done, checksum, timeout counter = 0.
- Transfer: beat = s_tvalid & s_tready. All checks act only on a beat, except the timeout check.
- Ready generation, registered, 1-cycle latency from ready_mode:
  - Every cycle: prbs <= {prbs[31:0], prbs[32] ^ ~prbs[19]}.
  - Mode 0: s_tready <= 1.
  - Mode 1: s_tready <= prbs[32].
  - Mode 2: s_tready <= s_tvalid & ~s_tready.
  - Mode 3: s_tready <= 0.
  - A mode change mid-frame takes effect on the next cycle; position tracking is not disturbed.
- Position FSM, states EXPECT_SOF and IN_FRAME; reset state is EXPECT_SOF.
- EXPECT_SOF, beat:
  - If tuser: frame_count++, state goes to IN_FRAME.
  - Otherwise: err_sof_missing++; the word is still counted as word 0 and state goes to IN_FRAME without incrementing frame_count.
- IN_FRAME, beat with tuser: err_sof_unexpected++, frame_count++. This word becomes word 0 of line 0 and is then processed by the EOL rules with x=0.
- EOL rules on every beat, evaluated after the SOF handling:
  - x==X_SIZE-1 and tlast: x<=0, y++.
  - x==X_SIZE-1 and no tlast: err_eol_missing++, x++.
  - x>X_SIZE-1 (overrun): x++ with no further error until tlast arrives; on tlast, x<=0, y++ with no unexpected-EOL error.
  - x<X_SIZE-1 and tlast: err_eol_unexpected++, x<=0, y++.
  - Otherwise: x++.
- End of frame: when y would become Y_SIZE, y<=0, state goes to EXPECT_SOF, and frame_done pulses in the cycle after the beat.
- X_SIZE=1: every word must carry tlast.
- Timeout:
  - The counter increments on each cycle with s_tvalid=0 and clears on s_tvalid=1.
  - On reaching TIMEOUT: err_timeout++ and the counter restarts from 0, so one error is counted per TIMEOUT idle cycles.
- Error counters:
  - Saturate at 2^ERR_W-1.
  - Any error event sets err_any.
  - clear_errors zeroes all counters and err_any; an event in the same cycle as clear_errors is dropped (clear wins).
  - Multiple distinct errors on one beat each increment their own counter.
- x_pos, y_pos, frame_count are 16-bit; x_pos saturates at 16'hFFFF during overrun.

Optional Feature:
- Macro: FRAME_CHECKSUM_EN.
- Defined:
  - Accumulator acc <= {acc[30:0],acc[31]} ^ zero-extended/truncated s_tdata on each beat.
  - acc is reset to the SOF word's contribution on an accepted SOF.
  - On the frame_done cycle, checksum <= final acc.
- Undefined: checksum is tied to 0 and no accumulator logic is generated.

Test Plan:
- Config X_SIZE=4, Y_SIZE=2, mode 0; one clean frame (SOF on beat 0, tlast on beats 3 and 7) -> frame_count=1, frame_done pulses once, all error counters 0, err_any=0.
- Same frame but tlast on beat 2 instead of 3 -> err_eol_unexpected=1; second line counted from beat 3; err_eol_missing=1 on beat 6 if the next tlast arrives late.
- SOF asserted on beat 5 of a frame -> err_sof_unexpected=1, frame_count=2, x_pos=1 after that beat.
- TIMEOUT=10, tvalid held low 25 cycles -> err_timeout=2; clear_errors pulse -> all counters 0 next cycle.
- Mode 2 with tvalid constantly high -> s_tready toggles 0,1,0,1 and beats occur every 2nd cycle; mode 3 -> zero beats, x_pos frozen.
- With FRAME_CHECKSUM_EN defined, frame data 1,2,3,4,5,6,7,8 -> checksum equals the software model of the rotate-XOR, latched on frame_done.

Source files
------------

// File: rtl/axis_video_checker.sv
// ---------------------------------------------------------------------------
// axis_video_checker
//
// AXI-Stream video sink and monitor. Generates tready in one of four
// backpressure modes, follows the word/line/frame position of the incoming
// stream, and counts framing errors and valid-timeouts in saturating
// counters that a bench or an on-chip debug register bank can read.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_tdata/s_tvalid    stream data and valid
//   s_tuser/s_tlast     start of frame / end of line markers
//   s_tready            registered stream ready
//   ready_mode          0 always, 1 PRBS, 2 ready-after-valid, 3 stall
//   clear_errors        synchronous clear of error counters and err_any
//   x_pos/y_pos         current word index / line index
//   frame_count         accepted SOFs, wraps
//   frame_done          one-cycle pulse after the last EOL of a frame
//   err_*               saturating error counters
//   err_any             sticky OR of all error events
//   checksum            rotate-XOR frame checksum
//
// Optional build macro: FRAME_CHECKSUM_EN enables the frame checksum
// accumulator; when undefined, checksum is tied to zero.
// ---------------------------------------------------------------------------
module axis_video_checker #(
   parameter int          DATA_W   = 32,
   parameter int          X_SIZE   = 480,
   parameter int          Y_SIZE   = 480,
   parameter int          TIMEOUT  = 1000,
   parameter int          ERR_W    = 16,
   parameter logic [32:0] RND_SEED = 33'd1246504138
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tuser,
   input  logic              s_tlast,
   output logic              s_tready,
   input  logic [1:0]        ready_mode,
   input  logic              clear_errors,
   output logic [15:0]       x_pos,
   output logic [15:0]       y_pos,
   output logic [15:0]       frame_count,
   output logic              frame_done,
   output logic [ERR_W-1:0]  err_sof_missing,
   output logic [ERR_W-1:0]  err_sof_unexpected,
   output logic [ERR_W-1:0]  err_eol_missing,
   output logic [ERR_W-1:0]  err_eol_unexpected,
   output logic [ERR_W-1:0]  err_timeout,
   output logic              err_any,
   output logic [31:0]       checksum
);

   typedef enum logic {EXPECT_SOF, IN_FRAME} state_t;

   localparam logic [15:0]      X_LAST  = 16'(X_SIZE - 1);
   localparam logic [15:0]      Y_LAST  = 16'(Y_SIZE - 1);
   localparam logic [31:0]      TO_LAST = 32'(TIMEOUT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [ERR_W-1:0] ERR_ONE = 1;

   state_t      state;
   logic [32:0] prbs;
   logic [31:0] idle_cnt;

   logic        beat;
   logic        at_start;
   logic        line_end;
   logic        frame_end;
   logic [15:0] x_eff;
   logic [15:0] y_eff;
   logic [15:0] x_next;
   logic [15:0] y_next;
   logic        ev_sof_missing;
   logic        ev_sof_unexpected;
   logic        ev_eol_missing;
   logic        ev_eol_unexpected;
   logic        ev_timeout;

   function automatic logic [ERR_W-1:0] bump(input logic [ERR_W-1:0] cnt, input logic ev);
      return (ev && (cnt != ERR_MAX)) ? cnt + ERR_ONE : cnt;
   endfunction

   // Beat decode. Any SOF word, and any word arriving while a SOF is
   // expected, is treated as word 0 of line 0 before the EOL rules run.
   always_comb begin
      beat              = s_tvalid & s_tready;
      at_start          = (state == EXPECT_SOF) | s_tuser;
      x_eff             = at_start ? 16'd0 : x_pos;
      y_eff             = at_start ? 16'd0 : y_pos;
      ev_sof_missing    = beat & (state == EXPECT_SOF) & ~s_tuser;
      ev_sof_unexpected = beat & (state == IN_FRAME) & s_tuser;
      ev_eol_missing    = beat & (x_eff == X_LAST) & ~s_tlast;
      ev_eol_unexpected = beat & (x_eff < X_LAST) & s_tlast;
      line_end          = beat & s_tlast;
      frame_end         = line_end & (y_eff == Y_LAST);
      if (s_tlast)
         x_next = 16'd0;
      else if (x_eff == 16'hFFFF)
         x_next = x_eff;
      else
         x_next = x_eff + 16'd1;
      if (!s_tlast)
         y_next = y_eff;
      else if (y_eff == Y_LAST)
         y_next = 16'd0;
      else
         y_next = y_eff + 16'd1;
      ev_timeout = (TIMEOUT != 0) && !s_tvalid && (idle_cnt == TO_LAST);
   end

   // Ready generator: the PRBS free-runs every cycle so mode 1 stays
   // deterministic relative to reset regardless of mode switches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prbs     <= RND_SEED;
         s_tready <= 1'b0;
      end else begin
         prbs <= {prbs[31:0], prbs[32] ^ ~prbs[19]};
         case (ready_mode)
            2'd0:    s_tready <= 1'b1;
            2'd1:    s_tready <= prbs[32];
            2'd2:    s_tready <= s_tvalid & ~s_tready;
            default: s_tready <= 1'b0;
         endcase
      end
   end

   // Position tracking FSM; frame_done is the registered frame-end beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= EXPECT_SOF;
         x_pos       <= 16'd0;
         y_pos       <= 16'd0;
         frame_count <= 16'd0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (beat) begin
            x_pos <= x_next;
            y_pos <= y_next;
            if (s_tuser)
               frame_count <= frame_count + 16'd1;
            state <= frame_end ? EXPECT_SOF : IN_FRAME;
         end
      end
   end

   // Idle counter restarts after each timeout so errors accrue once per
   // TIMEOUT idle cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idle_cnt <= 32'd0;
      else if ((TIMEOUT == 0) || s_tvalid || (idle_cnt == TO_LAST))
         idle_cnt <= 32'd0;
      else
         idle_cnt <= idle_cnt + 32'd1;
   end

   // Saturating error counters; a clear in the same cycle as an event wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sof_missing    <= '0;
         err_sof_unexpected <= '0;
         err_eol_missing    <= '0;
         err_eol_unexpected <= '0;
         err_timeout        <= '0;
         err_any            <= 1'b0;
      end else if (clear_errors) begin
         err_sof_missing    <= '0;
         err_sof_unexpected <= '0;
         err_eol_missing    <= '0;
         err_eol_unexpected <= '0;
         err_timeout        <= '0;
         err_any            <= 1'b0;
      end else begin
         err_sof_missing    <= bump(err_sof_missing, ev_sof_missing);
         err_sof_unexpected <= bump(err_sof_unexpected, ev_sof_unexpected);
         err_eol_missing    <= bump(err_eol_missing, ev_eol_missing);
         err_eol_unexpected <= bump(err_eol_unexpected, ev_eol_unexpected);
         err_timeout        <= bump(err_timeout, ev_timeout);
         err_any            <= err_any | ev_sof_missing | ev_sof_unexpected |
                               ev_eol_missing | ev_eol_unexpected | ev_timeout;
      end
   end

`ifdef FRAME_CHECKSUM_EN
   logic [31:0] acc;
   logic [31:0] data_word;

   assign data_word = 32'(s_tdata);

   // Rotate-XOR accumulator, restarted by an accepted SOF word; the result
   // is published on the frame_done cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= 32'd0;
         checksum <= 32'd0;
      end else begin
         if (beat)
            acc <= s_tuser ? data_word : ({acc[30:0], acc[31]} ^ data_word);
         if (frame_done)
            checksum <= acc;
      end
   end
`else
   logic unused_data;

   assign unused_data = ^s_tdata;
   assign checksum    = 32'd0;
`endif

endmodule

// File: tb/tb_axis_video_checker.sv
// ---------------------------------------------------------------------------
// tb_axis_video_checker
//
// Self-checking bench for axis_video_checker with a small 4x2 frame,
// TIMEOUT=10 and 4-bit error counters. A vector table covers clean and
// damaged frames; hand-written sequences cover stall, ready-after-valid,
// timeout, saturation, clear priority and PRBS ready.
// ---------------------------------------------------------------------------
module tb_axis_video_checker;

   localparam int          DATA_W  = 32;
   localparam int          X_SIZE  = 4;
   localparam int          Y_SIZE  = 2;
   localparam int          TIMEOUT = 10;
   localparam int          ERR_W   = 4;
   localparam logic [32:0] SEED    = 33'd1246504138;
`ifdef FRAME_CHECKSUM_EN
   localparam logic [31:0] CKS     = 32'd22;
`else
   localparam logic [31:0] CKS     = 32'd0;
`endif

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic              s_tuser;
   logic              s_tlast;
   logic              s_tready;
   logic [1:0]        ready_mode;
   logic              clear_errors;
   logic [15:0]       x_pos;
   logic [15:0]       y_pos;
   logic [15:0]       frame_count;
   logic              frame_done;
   logic [ERR_W-1:0]  err_sof_missing;
   logic [ERR_W-1:0]  err_sof_unexpected;
   logic [ERR_W-1:0]  err_eol_missing;
   logic [ERR_W-1:0]  err_eol_unexpected;
   logic [ERR_W-1:0]  err_timeout;
   logic              err_any;
   logic [31:0]       checksum;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic             v, u, l, clr;
      logic [31:0]      data;
      logic [15:0]      ex, ey, efc;
      logic             edone;
      logic [ERR_W-1:0] sofm, sofu, eolm, eolu;
      logic             eany;
      logic             chk_en;
      logic [31:0]      echk;
   } vec_t;

   vec_t vecs[$];

   axis_video_checker #(
      .DATA_W(DATA_W), .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE),
      .TIMEOUT(TIMEOUT), .ERR_W(ERR_W), .RND_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast),
      .s_tready(s_tready), .ready_mode(ready_mode), .clear_errors(clear_errors),
      .x_pos(x_pos), .y_pos(y_pos), .frame_count(frame_count), .frame_done(frame_done),
      .err_sof_missing(err_sof_missing), .err_sof_unexpected(err_sof_unexpected),
      .err_eol_missing(err_eol_missing), .err_eol_unexpected(err_eol_unexpected),
      .err_timeout(err_timeout), .err_any(err_any), .checksum(checksum)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference PRBS: ready in mode 1 equals the previous cycle's top bit
   logic [32:0] mprbs;
   logic        mready;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mprbs  <= SEED;
         mready <= 1'b0;
      end else begin
         mready <= mprbs[32];
         mprbs  <= {mprbs[31:0], mprbs[32] ^ ~mprbs[19]};
      end
   end

   // Guard against a run that never reaches its summary
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic addVec(input int v, u, l, clr, data, ex, ey, efc, edone,
                         sofm, sofu, eolm, eolu, eany, chk_en, input logic [31:0] echk);
      vec_t t;
      t.v = 1'(v); t.u = 1'(u); t.l = 1'(l); t.clr = 1'(clr);
      t.data = 32'(data);
      t.ex = 16'(ex); t.ey = 16'(ey); t.efc = 16'(efc); t.edone = 1'(edone);
      t.sofm = ERR_W'(sofm); t.sofu = ERR_W'(sofu);
      t.eolm = ERR_W'(eolm); t.eolu = ERR_W'(eolu);
      t.eany = 1'(eany); t.chk_en = 1'(chk_en); t.echk = echk;
      vecs.push_back(t);
   endtask

   // Drive one cycle of inputs and let one active edge pass
   task automatic applyStimulus(input logic v, u, l, clr, input logic [31:0] data);
      s_tvalid     = v;
      s_tuser      = u;
      s_tlast      = l;
      clear_errors = clr;
      s_tdata      = data;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] errPack();
      return 32'({err_sof_missing, err_sof_unexpected, err_eol_missing,
                  err_eol_unexpected, err_timeout});
   endfunction

   function automatic logic [31:0] expPack(input int sofm, sofu, eolm, eolu, tmo);
      return 32'({ERR_W'(sofm), ERR_W'(sofu), ERR_W'(eolm), ERR_W'(eolu), ERR_W'(tmo)});
   endfunction

   initial begin
      // v u l c data   x y fc dn  sm su em eu any  ck exp
      // Clean frame, data 1..8
      addVec(1,1,0,0,1, 1,0,1,0, 0,0,0,0,0, 1,0);
      addVec(1,0,0,0,2, 2,0,1,0, 0,0,0,0,0, 1,0);
      addVec(1,0,0,0,3, 3,0,1,0, 0,0,0,0,0, 1,0);
      addVec(1,0,1,0,4, 0,1,1,0, 0,0,0,0,0, 1,0);
      addVec(1,0,0,0,5, 1,1,1,0, 0,0,0,0,0, 1,0);
      addVec(1,0,0,0,6, 2,1,1,0, 0,0,0,0,0, 1,0);
      addVec(1,0,0,0,7, 3,1,1,0, 0,0,0,0,0, 1,0);
      addVec(1,0,1,0,8, 0,0,1,1, 0,0,0,0,0, 1,0);
      addVec(0,0,0,0,0, 0,0,1,0, 0,0,0,0,0, 1,CKS);
      // Early tlast on beat 2, late tlast on beat 7, all-zero data
      addVec(1,1,0,0,0, 1,0,2,0, 0,0,0,0,0, 1,CKS);
      addVec(1,0,0,0,0, 2,0,2,0, 0,0,0,0,0, 1,CKS);
      addVec(1,0,1,0,0, 0,1,2,0, 0,0,0,1,1, 1,CKS);
      addVec(1,0,0,0,0, 1,1,2,0, 0,0,0,1,1, 1,CKS);
      addVec(1,0,0,0,0, 2,1,2,0, 0,0,0,1,1, 1,CKS);
      addVec(1,0,0,0,0, 3,1,2,0, 0,0,0,1,1, 1,CKS);
      addVec(1,0,0,0,0, 4,1,2,0, 0,0,1,1,1, 1,CKS);
      addVec(1,0,1,0,0, 0,0,2,1, 0,0,1,1,1, 1,CKS);
      addVec(0,0,0,1,0, 0,0,2,0, 0,0,0,0,0, 1,0);
      // SOF repeated on beat 5
      addVec(1,1,0,0,0, 1,0,3,0, 0,0,0,0,0, 0,0);
      addVec(1,0,0,0,0, 2,0,3,0, 0,0,0,0,0, 0,0);
      addVec(1,0,0,0,0, 3,0,3,0, 0,0,0,0,0, 0,0);
      addVec(1,0,1,0,0, 0,1,3,0, 0,0,0,0,0, 0,0);
      addVec(1,0,0,0,0, 1,1,3,0, 0,0,0,0,0, 0,0);
      addVec(1,1,0,0,0, 1,0,4,0, 0,1,0,0,1, 0,0);
      addVec(1,0,0,0,0, 2,0,4,0, 0,1,0,0,1, 0,0);
      addVec(1,0,0,0,0, 3,0,4,0, 0,1,0,0,1, 0,0);
      addVec(1,0,1,0,0, 0,1,4,0, 0,1,0,0,1, 0,0);
      addVec(1,0,0,0,0, 1,1,4,0, 0,1,0,0,1, 0,0);
      addVec(1,0,0,0,0, 2,1,4,0, 0,1,0,0,1, 0,0);
      addVec(1,0,0,0,0, 3,1,4,0, 0,1,0,0,1, 0,0);
      addVec(1,0,1,0,0, 0,0,4,1, 0,1,0,0,1, 0,0);
      // Missing SOF, then SOF+tlast together on word 0 of line 1
      addVec(1,0,0,0,0, 1,0,4,0, 1,1,0,0,1, 0,0);
      addVec(1,0,0,0,0, 2,0,4,0, 1,1,0,0,1, 0,0);
      addVec(1,0,0,0,0, 3,0,4,0, 1,1,0,0,1, 0,0);
      addVec(1,0,1,0,0, 0,1,4,0, 1,1,0,0,1, 0,0);
      addVec(1,1,1,0,0, 0,1,5,0, 1,2,0,1,1, 0,0);
      addVec(1,0,0,0,0, 1,1,5,0, 1,2,0,1,1, 0,0);
      addVec(1,0,0,0,0, 2,1,5,0, 1,2,0,1,1, 0,0);
      addVec(1,0,0,0,0, 3,1,5,0, 1,2,0,1,1, 0,0);
      addVec(1,0,1,0,0, 0,0,5,1, 1,2,0,1,1, 0,0);

      rst = 1'b1; ready_mode = 2'd0;
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; clear_errors = 1'b0; s_tdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("reset_tready", 32'(s_tready), 32'd0);
      checkOutput("reset_x", 32'(x_pos), 32'd0);
      checkOutput("reset_y", 32'(y_pos), 32'd0);
      checkOutput("reset_fc", 32'(frame_count), 32'd0);
      checkOutput("reset_errs", errPack(), 32'd0);
      checkOutput("reset_any", 32'(err_any), 32'd0);
      checkOutput("reset_done", 32'(frame_done), 32'd0);
      checkOutput("reset_checksum", checksum, 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("mode0_tready", 32'(s_tready), 32'd1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].v, vecs[i].u, vecs[i].l, vecs[i].clr, vecs[i].data);
         checkOutput($sformatf("v%0d_x", i), 32'(x_pos), 32'(vecs[i].ex));
         checkOutput($sformatf("v%0d_y", i), 32'(y_pos), 32'(vecs[i].ey));
         checkOutput($sformatf("v%0d_fc", i), 32'(frame_count), 32'(vecs[i].efc));
         checkOutput($sformatf("v%0d_done", i), 32'(frame_done), 32'(vecs[i].edone));
         checkOutput($sformatf("v%0d_errs", i), errPack(),
                     expPack(int'(vecs[i].sofm), int'(vecs[i].sofu),
                             int'(vecs[i].eolm), int'(vecs[i].eolu), 0));
         checkOutput($sformatf("v%0d_any", i), 32'(err_any), 32'(vecs[i].eany));
         if (vecs[i].chk_en)
            checkOutput($sformatf("v%0d_checksum", i), checksum, vecs[i].echk);
      end

      // Stall: valid held high, no beats accepted
      ready_mode = 2'd3;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("stall_tready", 32'(s_tready), 32'd0);
      checkOutput("stall_x", 32'(x_pos), 32'd0);
      checkOutput("stall_fc", 32'(frame_count), 32'd5);

      // Ready-after-valid: ready alternates, one beat every second cycle
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
      ready_mode = 2'd2;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
         checkOutput($sformatf("mode2_tready_%0d", i), 32'(s_tready), 32'(i % 2));
      end
      checkOutput("mode2_x_overrun", 32'(x_pos), 32'd4);
      checkOutput("mode2_errs", errPack(), expPack(1, 0, 1, 0, 0));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("overrun_eol_x", 32'(x_pos), 32'd0);
      checkOutput("overrun_eol_y", 32'(y_pos), 32'd1);
      checkOutput("overrun_eol_errs", errPack(), expPack(1, 0, 1, 0, 0));

      // Timeout: 25 idle cycles give two events
      ready_mode = 2'd3;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
      for (int i = 0; i < 25; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("timeout_errs", errPack(), expPack(0, 0, 0, 0, 2));
      checkOutput("timeout_any", 32'(err_any), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput("clear_errs", errPack(), 32'd0);
      checkOutput("clear_any", 32'(err_any), 32'd0);

      // Saturation, then a clear coinciding with a timeout event
      for (int i = 0; i < 200; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("timeout_saturate", 32'(err_timeout), 32'd15);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
      checkOutput("clear_wins_tmo", 32'(err_timeout), 32'd0);
      checkOutput("clear_wins_any", 32'(err_any), 32'd0);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("timeout_restart", 32'(err_timeout), 32'd1);

      // PRBS ready follows the reference generator
      ready_mode = 2'd1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
         checkOutput($sformatf("prbs_tready_%0d", i), 32'(s_tready), 32'(mready));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
